// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } hz_state_e;

    // Register $zero: a load targeting it never creates a dependency.
    localparam int REG_ZERO = 0;

    // Consecutive data-memory wait cycles tolerated before flagging an error.
    localparam int DEF_MEM_TIMEOUT = 255;

endpackage

// File: rtl/pipeline_hazard_ctrl_mem_wait_timer.sv
// Saturating data-memory wait counter with a sticky timeout flag.
// Counts enabled cycles up to MAX and holds there; clr returns it to zero.
// The flag stays set once the count reaches MAX, until reset.
module mem_wait_timer
    import hazard_pkg::*;
#(
    parameter int MAX = DEF_MEM_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int W = $clog2(MAX + 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         timeout_q, timeout_d;

    // Next count: clear wins, otherwise count up and hold at MAX.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != W'(MAX))) begin
            cnt_d = cnt_q + W'(1);
        end
        if (cnt_d == W'(MAX)) begin
            timeout_d = 1'b1;
        end
    end

    // Counter and sticky flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall / bubble / redirect sequencer for the 5-stage pipeline.
// Build option: define HAZARD_PERF_EN to get stall and redirect counters;
// without it both perf ports are tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; resolves load-use and taken branches directly
// MEM_WAIT | data memory stalling; whole pipe frozen until dmem_ready
// REDIRECT | replays a branch taken during the wait; flushes IF/ID
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int REG_W       = 5,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              mem_req,
    input  logic              dmem_ready,
    output logic              stall,
    output logic              pc_mux_sel,
    output logic [ADDR_W-1:0] pc_jump,
    output logic              bubble_ex,
    output logic              stall_all,
    output logic              mem_timeout,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
);

    hz_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pend_q, pend_d;
    logic              pend_v_q, pend_v_d;
    logic              tmr_en, tmr_clr;
    logic              load_use, mem_wait;

    assign load_use = ex_mem_read && (ex_rd != REG_W'(REG_ZERO)) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
    assign mem_wait = mem_req && !dmem_ready;

    // Next state and Mealy outputs; outputs are forced low while rst is held
    // so an asynchronous reset silences the pipeline controls at once.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_v_d   = pend_v_q;
        stall      = 1'b0;
        stall_all  = 1'b0;
        bubble_ex  = 1'b0;
        pc_mux_sel = 1'b0;
        pc_jump    = '0;
        tmr_en     = 1'b0;
        tmr_clr    = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (mem_wait) begin
                        stall     = 1'b1;
                        stall_all = 1'b1;
                        tmr_en    = 1'b1;
                        // A branch resolved as the pipe freezes must not be lost.
                        if (br_taken) begin
                            pend_d   = br_target;
                            pend_v_d = 1'b1;
                        end
                        state_d = MEM_WAIT;
                    end else if (load_use) begin
                        stall     = 1'b1;
                        bubble_ex = 1'b1;
                    end else if (br_taken) begin
                        pc_mux_sel = 1'b1;
                        pc_jump    = br_target;
                    end
                end
                MEM_WAIT: begin
                    if (mem_wait) begin
                        stall     = 1'b1;
                        stall_all = 1'b1;
                        tmr_en    = 1'b1;
                    end else begin
                        tmr_clr = 1'b1;
                        state_d = pend_v_q ? REDIRECT : RUN;
                    end
                end
                REDIRECT: begin
                    // IF/ID is flushed this cycle, so inputs are not examined;
                    // a fresh memory wait is picked up next cycle in RUN.
                    pc_mux_sel = 1'b1;
                    pc_jump    = pend_q;
                    pend_v_d   = 1'b0;
                    state_d    = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    // State and pending-redirect registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
        end
    end

    mem_wait_timer #(
        .MAX (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .timeout (mem_timeout)
    );

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Free-running event counters, wrapping modulo 2^32.
    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (stall)      perf_stall_d = perf_stall_q + 32'd1;
        if (pc_mux_sel) perf_flush_d = perf_flush_q + 32'd1;
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus
// randomized traffic against a behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
    logic        id_uses_rt = 1'b0, ex_mem_read = 1'b0, br_taken = 1'b0;
    logic [31:0] br_target = '0;
    logic        mem_req = 1'b0, dmem_ready = 1'b0;
    logic        stall, pc_mux_sel, bubble_ex, stall_all, mem_timeout;
    logic [31:0] pc_jump, perf_stall_cnt, perf_flush_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model state
    bit          m_waiting, m_redir_due, m_pend_v, m_timeout;
    int          m_wait_cnt;
    logic [31:0] m_pend_tgt, m_perf_stall, m_perf_flush;

    pipeline_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .ex_mem_read    (ex_mem_read),
        .ex_rd          (ex_rd),
        .br_taken       (br_taken),
        .br_target      (br_target),
        .mem_req        (mem_req),
        .dmem_ready     (dmem_ready),
        .stall          (stall),
        .pc_mux_sel     (pc_mux_sel),
        .pc_jump        (pc_jump),
        .bubble_ex      (bubble_ex),
        .stall_all      (stall_all),
        .mem_timeout    (mem_timeout),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_waiting = 0; m_redir_due = 0; m_pend_v = 0; m_timeout = 0;
        m_wait_cnt = 0; m_pend_tgt = '0; m_perf_stall = '0; m_perf_flush = '0;
    endtask

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_rd = '0; id_uses_rt = 0; ex_mem_read = 0;
        br_taken = 0; br_target = '0; mem_req = 0; dmem_ready = 0;
    endtask

    // Compare every output against the model for the current inputs, advance
    // the model by one cycle, then move to 1ns after the next rising edge.
    task automatic tick();
        bit e_stall, e_all, e_bub, e_sel, mw, lu;
        logic [31:0] e_jump;
        #1;
        mw = mem_req && !dmem_ready;
        lu = ex_mem_read && (ex_rd != 0) &&
             ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        e_stall = 0; e_all = 0; e_bub = 0; e_sel = 0; e_jump = '0;
        if (m_redir_due) begin
            e_sel = 1; e_jump = m_pend_tgt;
        end else if (m_waiting && !mw) begin
            // ready cycle: everything released
        end else if (mw) begin
            e_stall = 1; e_all = 1;
        end else if (lu) begin
            e_stall = 1; e_bub = 1;
        end else if (br_taken) begin
            e_sel = 1; e_jump = br_target;
        end
        chk("stall", 32'(stall), 32'(e_stall));
        chk("stall_all", 32'(stall_all), 32'(e_all));
        chk("bubble_ex", 32'(bubble_ex), 32'(e_bub));
        chk("pc_mux_sel", 32'(pc_mux_sel), 32'(e_sel));
        chk("pc_jump", pc_jump, e_jump);
        chk("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
        chk("perf_stall", perf_stall_cnt, m_perf_stall);
        chk("perf_flush", perf_flush_cnt, m_perf_flush);
        if (m_redir_due) begin
            m_redir_due = 0; m_pend_v = 0;
        end else if (mw) begin
            if (!m_waiting && br_taken) begin
                m_pend_v = 1; m_pend_tgt = br_target;
            end
            m_waiting = 1;
            if (m_wait_cnt < 255) m_wait_cnt++;
            if (m_wait_cnt == 255) m_timeout = 1;
        end else if (m_waiting) begin
            m_waiting = 0; m_wait_cnt = 0; m_redir_due = m_pend_v;
        end
`ifdef HAZARD_PERF_EN
        if (e_stall) m_perf_stall = m_perf_stall + 1;
        if (e_sel)   m_perf_flush = m_perf_flush + 1;
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] exp_perf;
        model_reset();
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 0);
        chk("rst_pc_jump", pc_jump, 0);
        chk("rst_timeout", 32'(mem_timeout), 0);
        rst = 0;
        tick();

        // Load-use on rs, then $zero destination
        ex_mem_read = 1; ex_rd = 5; id_rs = 5;
        #1;
        chk("lu_stall", 32'(stall), 1);
        chk("lu_bubble", 32'(bubble_ex), 1);
        tick();
        ex_mem_read = 0;
        #1;
        chk("lu_release", 32'(stall), 0);
        tick();
        ex_mem_read = 1; ex_rd = 0; id_rs = 0; id_rt = 0; id_uses_rt = 1;
        #1;
        chk("lu_zero", 32'(stall), 0);
        tick();
        idle_inputs();

        // Taken branch in RUN
        br_taken = 1; br_target = 32'h40;
        #1;
        chk("br_sel", 32'(pc_mux_sel), 1);
        chk("br_jump", pc_jump, 32'h40);
        tick();
        br_taken = 0;
        #1;
        chk("br_one_cycle", 32'(pc_mux_sel), 0);
        tick();

`ifdef HAZARD_PERF_EN
        exp_perf = 32'd1;
`else
        exp_perf = 32'd0;
`endif
        chk("perf_stall_after_1_2", perf_stall_cnt, exp_perf);
        chk("perf_flush_after_1_2", perf_flush_cnt, exp_perf);

        // Memory wait with branch latched in the first cycle
        mem_req = 1; dmem_ready = 0; br_taken = 1; br_target = 32'h80;
        #1;
        chk("mw_all_1", 32'(stall_all), 1);
        chk("mw_no_redirect", 32'(pc_mux_sel), 0);
        tick();
        br_taken = 0;
        for (int i = 2; i <= 3; i++) begin
            #1;
            chk("mw_all_n", 32'(stall_all), 1);
            tick();
        end
        dmem_ready = 1;
        #1;
        chk("mw_ready_release", 32'(stall), 0);
        tick();
        mem_req = 0;
        #1;
        chk("mw_redir_sel", 32'(pc_mux_sel), 1);
        chk("mw_redir_jump", pc_jump, 32'h80);
        tick();
        tick();

        // Asynchronous reset during a wait with a pending redirect
        mem_req = 1; dmem_ready = 0; br_taken = 1; br_target = 32'h99;
        tick();
        br_taken = 0;
        tick();
        #3;
        rst = 1;
        #1;
        chk("arst_stall", 32'(stall), 0);
        chk("arst_stall_all", 32'(stall_all), 0);
        chk("arst_sel", 32'(pc_mux_sel), 0);
        chk("arst_jump", pc_jump, 0);
        model_reset();
        idle_inputs();
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("arst_no_redirect", 32'(pc_mux_sel), 0);
            tick();
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_uses_rt  = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            br_taken    = ($urandom_range(0, 3) == 0);
            br_target   = $urandom;
            mem_req     = ($urandom_range(0, 9) < 3);
            dmem_ready  = ($urandom_range(0, 9) < 6);
            tick();
        end
        idle_inputs();
        tick();
        tick();

        // Long wait reaching the timeout
        mem_req = 1; dmem_ready = 0;
        for (int i = 1; i <= 260; i++) begin
            tick();
            if (i == 254) chk("to_before", 32'(mem_timeout), 0);
            if (i == 255) chk("to_reached", 32'(mem_timeout), 1);
        end
        dmem_ready = 1;
        tick();
        mem_req = 0;
        tick();
        chk("to_sticky", 32'(mem_timeout), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
